// File: rtl/frequency_generator.sv
// Two-tone FSK transmitter: serializes bytes MSB-first as a square wave,
// one tone per bit, and keeps cumulative per-tone SEND tick counts.
module frequency_generator #(
  parameter int FREQUENCY_1 = 9000,
  parameter int FREQUENCY_2 = 11000,
  parameter int CLOCK       = 50000000,
  parameter int BIT_TICKS   = 50000
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        enable,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sample_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] f1_value,
  output logic [31:0] f2_value
);

  localparam int HALF1 = CLOCK / (2 * FREQUENCY_1);
  localparam int HALF2 = CLOCK / (2 * FREQUENCY_2);
  localparam int BW    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int HW    = (HALF1 > 0) ? $clog2(HALF1 + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST   = BW'(BIT_TICKS - 1);
  localparam logic [HW-1:0] HALF1_LAST = HW'(HALF1 - 1);
  localparam logic [HW-1:0] HALF2_LAST = HW'(HALF2 - 1);

  if (HALF2 < 1) begin : g_bad_half2
    $error("frequency_generator: HALF2 must be at least 1");
  end
  if (HALF1 <= HALF2) begin : g_bad_order
    $error("frequency_generator: HALF1 must exceed HALF2");
  end
  if (BIT_TICKS < 2 * HALF1) begin : g_bad_bit_ticks
    $error("frequency_generator: BIT_TICKS must cover a full FREQUENCY_1 period");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_shreg;
  logic [2:0]      r_bit_idx;
  logic [BW-1:0]   r_bit_cnt;
  logic [HW-1:0]   r_half_cnt;
  logic            r_sample;
  logic            r_busy;
  logic            r_done;
  logic            r_tx_ready;
  logic [31:0]     r_f1;
  logic [31:0]     r_f2;

  logic            w_accept;
  logic            w_bit_end;
  logic            w_last_bit;
  logic [HW-1:0]   w_half_last;
  logic            w_half_end;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  assign w_accept    = (r_state == ST_IDLE) && tx_valid && r_tx_ready;
  assign w_bit_end   = (r_bit_cnt == BIT_LAST);
  assign w_last_bit  = (r_bit_idx == 3'd0);
  assign w_half_last = r_shreg[7] ? HALF2_LAST : HALF1_LAST;
  assign w_half_end  = (r_half_cnt == w_half_last);

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: leave SEND on abort or after the final bit period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bit_end && w_last_bit) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Serializer, tone generator and per-tone tick counters.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_shreg    <= 8'd0;
      r_bit_idx  <= 3'd0;
      r_bit_cnt  <= '0;
      r_half_cnt <= '0;
      r_sample   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_f1       <= 32'd0;
      r_f2       <= 32'd0;
    end else begin
      r_done     <= 1'b0;
      r_tx_ready <= (w_state_nxt == ST_IDLE) && enable;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shreg    <= tx_data;
            r_bit_idx  <= 3'd7;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_sample   <= 1'b1;
            r_busy     <= 1'b1;
          end else begin
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
          end
        end
        ST_SEND: begin
          if (!enable) begin
            // Abort: drop the partial byte, keep the ticks already counted.
            r_shreg    <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_bit_cnt  <= '0;
            r_half_cnt <= '0;
            r_sample   <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            if (r_shreg[7]) begin
              r_f2 <= sat_inc(r_f2);
            end else begin
              r_f1 <= sat_inc(r_f1);
            end
            if (w_bit_end && w_last_bit) begin
              r_shreg    <= 8'd0;
              r_bit_cnt  <= '0;
              r_half_cnt <= '0;
              r_sample   <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else if (w_bit_end) begin
              // One toggle at the boundary wins over a coincident half-period toggle.
              r_shreg    <= {r_shreg[6:0], 1'b0};
              r_bit_idx  <= r_bit_idx - 3'd1;
              r_bit_cnt  <= '0;
              r_half_cnt <= '0;
              r_sample   <= ~r_sample;
            end else begin
              r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
              if (w_half_end) begin
                r_half_cnt <= '0;
                r_sample   <= ~r_sample;
              end else begin
                r_half_cnt <= r_half_cnt + {{(HW-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        default: begin
          r_sample <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready    = r_tx_ready;
  assign sample_data = r_sample;
  assign busy        = r_busy;
  assign done        = r_done;
  assign f1_value    = r_f1;
  assign f2_value    = r_f2;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator with a small tone-waveform model
// (CLOCK=1000, F1=50, F2=100, BIT_TICKS=40 -> 10- and 5-clock half periods).
module tb_frequency_generator;

  logic        clock;
  logic        clear_n;
  logic        enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        sample_data;
  logic        busy;
  logic        done;
  logic [31:0] f1_value;
  logic [31:0] f2_value;

  int n_checks = 0;
  int n_errors = 0;
  int exp_f1   = 0;
  int exp_f2   = 0;

  frequency_generator #(
    .FREQUENCY_1(50),
    .FREQUENCY_2(100),
    .CLOCK      (1000),
    .BIT_TICKS  (40)
  ) u_dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .enable     (enable),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .sample_data(sample_data),
    .busy       (busy),
    .done       (done),
    .f1_value   (f1_value),
    .f2_value   (f2_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called in SEND cycle 0; walks the frame against the model. Ends in the
  // done cycle, or in the cycle after the abort edge when abort_at >= 0.
  task automatic run_frame(input logic [7:0] b, input int abort_at, input string tag);
    int   bad;
    int   n;
    int   half;
    int   o;
    logic bit_v;
    logic expv;
    bad = 0;
    n = (abort_at >= 0) ? abort_at : 320;
    for (int k = 0; k < n; k++) begin
      bit_v = b[7 - k / 40];
      half  = bit_v ? 5 : 10;
      o     = k % 40;
      expv  = ((o / half) % 2) == 0;
      if (sample_data !== expv || busy !== 1'b1 || done !== 1'b0 || tx_ready !== 1'b0) begin
        bad++;
      end
      if (bit_v) exp_f2++;
      else exp_f1++;
      tick();
    end
    chk({tag, "_wave"}, bad, 32'd0);
    if (abort_at >= 0) begin
      enable = 1'b0;
      tick();
      chk({tag, "_abort_done"}, {31'd0, done}, 32'd0);
    end else begin
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
    end
    chk({tag, "_sample0"}, {31'd0, sample_data}, 32'd0);
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
    chk({tag, "_f1"}, f1_value, exp_f1);
    chk({tag, "_f2"}, f2_value, exp_f2);
  endtask

  task automatic handshake(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    clear_n  = 1'b0;
    enable   = 1'b0;
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    repeat (2) tick();
    chk("rst_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    clear_n = 1'b1;
    tick();
    chk("ready_dis", {31'd0, tx_ready}, 32'd0);
    enable = 1'b1;
    tick();
    chk("ready_en", {31'd0, tx_ready}, 32'd1);

    // Asynchronous reset in the middle of a frame.
    handshake(8'hFF);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    repeat (30) tick();
    clear_n = 1'b0;
    #1;
    chk("arst_sample", {31'd0, sample_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_ready", {31'd0, tx_ready}, 32'd0);
    chk("arst_f1", f1_value, 32'd0);
    chk("arst_f2", f2_value, 32'd0);
    enable = 1'b0;
    tick();
    clear_n = 1'b1;
    tick();
    chk("rel_ready_dis", {31'd0, tx_ready}, 32'd0);
    enable = 1'b1;
    tick();
    chk("rel_ready_en", {31'd0, tx_ready}, 32'd1);

    // 0x00: all low tone.
    handshake(8'h00);
    run_frame(8'h00, -1, "b00");
    chk("b00_f1_abs", f1_value, 32'd320);
    chk("b00_f2_abs", f2_value, 32'd0);
    tick();
    chk("b00_done_once", {31'd0, done}, 32'd0);
    chk("b00_ready", {31'd0, tx_ready}, 32'd1);

    // 0xFF: all high tone.
    handshake(8'hFF);
    run_frame(8'hFF, -1, "bff");
    chk("bff_f1_abs", f1_value, 32'd320);
    chk("bff_f2_abs", f2_value, 32'd320);
    tick();
    chk("bff_done_once", {31'd0, done}, 32'd0);

    // 0xA5: alternating tones with boundary toggles.
    handshake(8'hA5);
    run_frame(8'hA5, -1, "ba5");
    chk("ba5_f1_abs", f1_value, 32'd480);
    chk("ba5_f2_abs", f2_value, 32'd480);
    tick();

    // Abort at SEND cycle 100 of 0x00.
    handshake(8'h00);
    run_frame(8'h00, 100, "abt");
    chk("abt_f1_abs", f1_value, 32'd580);
    tick();
    chk("abt_no_done", {31'd0, done}, 32'd0);
    chk("abt_ready_dis", {31'd0, tx_ready}, 32'd0);
    enable = 1'b1;
    tick();
    chk("abt_ready_en", {31'd0, tx_ready}, 32'd1);
    handshake(8'h81);
    run_frame(8'h81, -1, "b81");
    chk("b81_f1_abs", f1_value, 32'd820);
    chk("b81_f2_abs", f2_value, 32'd560);
    tick();

    // tx_valid held; data changes mid-frame.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hC3;
    run_frame(8'h3C, -1, "b3c");
    chk("b3c_ready_done", {31'd0, tx_ready}, 32'd1);
    tick();
    tx_valid = 1'b0;
    chk("bc3_started", {31'd0, busy}, 32'd1);
    run_frame(8'hC3, -1, "bc3");
    chk("bc3_f1_abs", f1_value, 32'd1140);
    chk("bc3_f2_abs", f2_value, 32'd880);
    tick();
    chk("bc3_idle_ready", {31'd0, tx_ready}, 32'd1);
    chk("bc3_idle_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
